// File: rtl/bin2bcd_engine_if.sv
// Handshake bundle between the converter controller (master) and the
// bin2bcd_engine (slave): start request, operand, busy/done status, BCD result.
interface bin2bcd_engine_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;

  modport master (
    output start,
    output bin_in,
    input  busy,
    input  done,
    input  bcd_out
  );

  modport slave (
    input  start,
    input  bin_in,
    output busy,
    output done,
    output bcd_out
  );
endinterface

// File: rtl/bin2bcd_engine.sv
// Sequential binary-to-BCD converter using shift-and-add-3 (double dabble),
// one operand bit per clock. Consumes the controller's start pulse and
// reports busy/done; bcd_out only changes on completion or reset.
//
// Optional build macro BIN2BCD_LZ_SKIP_EN: skip the operand's leading zeros
// so small values finish early (zero completes in a single cycle). Results
// are identical with and without the macro.
module bin2bcd_engine #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  bin2bcd_engine_if.slave   bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // The largest operand must fit in the requested number of decimal digits.
  if ((64'd10 ** DIGITS) <= ((64'd1 << WIDTH) - 64'd1)) begin : g_digits_too_small
    $error("bin2bcd_engine: DIGITS too small for WIDTH");
  end

  logic [1:0]       state;
  logic [WIDTH-1:0] shift_reg;
  logic [BCD_W-1:0] scratch;
  logic [BCD_W-1:0] scratch_nxt;
  logic [BCD_W-1:0] bcd_q;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       dig;
  logic             carry;

  // One dabble step: add 3 to every digit >= 5, then shift left pulling in
  // the operand MSB; each digit's old bit 3 carries into the next digit.
  always_comb begin
    // NOTE: every variable gets a default before any conditional update so
    // no path leaves it unassigned (which would infer a latch).
    scratch_nxt = '0;
    dig         = '0;
    carry       = shift_reg[WIDTH-1];
    for (int d = 0; d < DIGITS; d++) begin
      dig = scratch[4*d +: 4];
      if (dig >= 4'd5) dig = dig + 4'd3;
      scratch_nxt[4*d +: 4] = {dig[2:0], carry};
      carry = dig[3];
    end
  end

`ifdef BIN2BCD_LZ_SKIP_EN
  logic [CNT_W-1:0] lz;

  // Leading-zero count of the incoming operand (WIDTH when it is zero).
  always_comb begin
    lz = CNT_W'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (bus.bin_in[i]) lz = CNT_W'(WIDTH - 1 - i);
    end
  end
`endif

  // Control FSM and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      shift_reg <= '0;
      scratch   <= '0;
      cnt       <= '0;
      bcd_q     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            scratch <= '0;
`ifdef BIN2BCD_LZ_SKIP_EN
            if (bus.bin_in == '0) begin
              shift_reg <= '0;
              cnt       <= '0;
              bcd_q     <= '0;
              state     <= ST_DONE;
            end else begin
              shift_reg <= bus.bin_in << lz;
              cnt       <= CNT_W'(WIDTH) - lz;
              state     <= ST_SHIFT;
            end
`else
            shift_reg <= bus.bin_in;
            cnt       <= CNT_W'(WIDTH);
            state     <= ST_SHIFT;
`endif
          end
        end
        ST_SHIFT: begin
          scratch   <= scratch_nxt;
          shift_reg <= shift_reg << 1;
          cnt       <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            bcd_q <= scratch_nxt;
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status is a pure decode of the registered state.
  assign bus.busy    = (state != ST_IDLE);
  assign bus.done    = (state == ST_DONE);
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_engine.sv
// Scoreboard bench for bin2bcd_engine (WIDTH=8, DIGITS=3). Stimulus pushes
// the expected BCD value and completion cycle; a monitor pops on every done.
// Expected latency follows BIN2BCD_LZ_SKIP_EN when it is defined.
module tb_bin2bcd_engine;

  localparam int W = 8;
  localparam int D = 3;

  typedef struct {
    int bcd;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t sb[$];
  exp_t mon_e;

  bin2bcd_engine_if #(.WIDTH(W), .DIGITS(D)) bus ();

  bin2bcd_engine #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic int exp_bcd(input int v);
    return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
  endfunction

  // Cycles from the start edge to done (done lands in cycle lat).
  function automatic int exp_lat(input int v);
`ifdef BIN2BCD_LZ_SKIP_EN
    int n = 0;
    for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
    return n + 1;
`else
    return (v >= 0) ? W + 1 : W + 1;
`endif
  endfunction

  // Monitor: every done must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: bcd_out=%h at cyc %0d", bus.bcd_out, cyc);
      end else begin
        mon_e = sb.pop_front();
        check("bcd_out", int'(bus.bcd_out), mon_e.bcd);
        check("done_cycle", cyc, mon_e.cyc);
      end
    end
  end

  // Wait (bounded) until the engine is idle; called and returns at a negedge.
  task automatic wait_idle(input int budget);
    int n = 0;
    while (bus.busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: busy still high after %0d cycles", budget);
    end
  endtask

  // Pulse start for one edge; returns at the negedge of cycle 1.
  task automatic issue(input int v);
    exp_t e;
    wait_idle(40);
    bus.start  = 1'b1;
    bus.bin_in = W'(v);
    e.bcd = exp_bcd(v);
    e.cyc = cyc + 1 + exp_lat(v) - 1;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k1, d1, k2, d2;
    int dir_vals[6] = '{0, 9, 10, 99, 100, 199};
    exp_t e;
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_bcd", int'(bus.bcd_out), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // 255: busy for exactly lat cycles, bcd_out holds 0 until done.
    issue(255);
    n = 0;
    while (bus.busy && n < 50) begin
      if (!bus.done) check("hold_prev", int'(bus.bcd_out), 0);
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, exp_lat(255));

    // Directed walk.
    foreach (dir_vals[i]) begin
      issue(dir_vals[i]);
      wait_idle(40);
    end

    // Exhaustive sweep.
    for (int v = 0; v < 256; v++) begin
      issue(v);
      wait_idle(40);
    end

    // Start pulsed mid-conversion with a new operand: ignored.
    issue(123);
    repeat (3) @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = W'(45);
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle(40);

    // Async reset in SHIFT cycle 4: outputs clear at once, no done follows.
    issue(77);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(bus.busy), 0);
    check("midrst_done", int'(bus.done), 0);
    check("midrst_bcd", int'(bus.bcd_out), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    issue(88);
    wait_idle(40);

    // start held high: 37 then 200 back to back.
    bus.start  = 1'b1;
    bus.bin_in = W'(37);
    k1 = cyc + 1;
    d1 = k1 + exp_lat(37) - 1;
    k2 = d1 + 2;
    d2 = k2 + exp_lat(200) - 1;
    e.bcd = exp_bcd(37);  e.cyc = d1; sb.push_back(e);
    e.bcd = exp_bcd(200); e.cyc = d2; sb.push_back(e);
    @(negedge clk);
    bus.bin_in = W'(200);
    n = 0;
    while (cyc < k2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    wait_idle(40);
    repeat (3) @(negedge clk);

    check("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
